// File: rtl/data_memory_ctrl.sv
// Data memory controller for the MEM stage: single-cycle stores, multi-cycle
// loads that stall the pipeline, with byte/half/word lanes and a sticky misalignment trap.
module data_memory_ctrl #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [1:0]  mem_size,
   input  logic        load_unsigned,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        addr_err,
   output logic [31:0] err_addr,
   output logic [1:0]  o_dbg_state
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [CW-1:0]  r_cnt;
   logic [AW-1:0]  r_ld_idx;
   logic [1:0]     r_ld_off;
   logic [1:0]     r_ld_size;
   logic           r_ld_unsigned;
   logic [31:0]    r_rdata;
   logic           r_addr_err;
   logic [31:0]    r_err_addr;
   logic [31:0]    r_mem [DEPTH_WORDS];

   logic [AW-1:0]  w_idx;
   logic           w_is_half;
   logic           w_is_word;
   logic           w_misaligned;
   logic           w_wr_en;
   logic           w_rd_start;
   logic           w_rd_finish;
   logic           w_err_set;
   logic [3:0]     w_be;
   logic [31:0]    w_wdata;
   logic [31:0]    w_rd_word;
   logic [7:0]     w_ld_byte;
   logic [15:0]    w_ld_half;
   logic [31:0]    w_ld_value;
   logic           w_unused;

   // Address bits above the memory size are dropped, so accesses wrap.
   assign w_idx        = mem_addr[AW+1:2];
   assign w_unused     = ^mem_addr[31:AW+2];
   assign w_is_half    = (mem_size == 2'b01);
   assign w_is_word    = mem_size[1];
   assign w_misaligned = (w_is_half & mem_addr[0]) |
                         (w_is_word & (mem_addr[1:0] != 2'b00));

   // Handshake: a request is accepted in IDLE in the cycle it is presented; the
   // pipeline must hold the request stage while stall=1, and DONE carries rdata.
   always_comb begin
      w_next_state = r_state;
      stall        = 1'b0;
      w_wr_en      = 1'b0;
      w_rd_start   = 1'b0;
      w_rd_finish  = 1'b0;
      w_err_set    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (MemRead || MemWrite) begin
               if (w_misaligned) begin
                  w_err_set = 1'b1;
               end else if (MemWrite) begin
                  w_wr_en = 1'b1;
               end else begin
                  w_rd_start   = 1'b1;
                  stall        = 1'b1;
                  w_next_state = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            stall = 1'b1;
            if (r_cnt == '0) begin
               w_rd_finish  = 1'b1;
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Store lane steering: narrow data is replicated so any enabled lane sees it.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = mem_wdata;
      if (mem_size == 2'b00) begin
         w_be    = 4'b0001 << mem_addr[1:0];
         w_wdata = {4{mem_wdata[7:0]}};
      end else if (w_is_half) begin
         w_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{mem_wdata[15:0]}};
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
   end

   assign w_rd_word = r_mem[r_ld_idx];
   assign w_ld_byte = w_rd_word[8*r_ld_off +: 8];
   assign w_ld_half = r_ld_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];

   always_comb begin
      w_ld_value = w_rd_word;
      if (r_ld_size == 2'b00) begin
         w_ld_value = r_ld_unsigned ? {24'd0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
      end else if (r_ld_size == 2'b01) begin
         w_ld_value = r_ld_unsigned ? {16'd0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_rdata       <= 32'd0;
         r_addr_err    <= 1'b0;
         r_err_addr    <= 32'd0;
         r_ld_idx      <= '0;
         r_ld_off      <= 2'b00;
         r_ld_size     <= 2'b00;
         r_ld_unsigned <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_rd_start) begin
            r_cnt         <= CW'(LATENCY - 1);
            r_ld_idx      <= w_idx;
            r_ld_off      <= mem_addr[1:0];
            r_ld_size     <= mem_size;
            r_ld_unsigned <= load_unsigned;
         end else if (r_state == ST_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_rd_finish) begin
            r_rdata <= w_ld_value;
         end
         // Only the first faulting address is kept until reset.
         if (w_err_set) begin
            r_addr_err <= 1'b1;
            if (!r_addr_err) begin
               r_err_addr <= mem_addr;
            end
         end
      end
   end

   assign rdata       = r_rdata;
   assign addr_err    = r_addr_err;
   assign err_addr    = r_err_addr;
   assign o_dbg_state = r_state;

endmodule
